// File: rtl/ad79xx_multi_if.sv
// ad79xx_multi_if
// Multi-channel serial front end for NCH simultaneously-sampling AD79xx-class
// SAR ADCs in 3-wire CS mode. A single CNV/SCLK pair is shared by all
// converters. The NCH SDO lines are deserialised in parallel, and one frame of
// NCH samples per conversion period is presented on a valid/ready stream.
//
// Optional feature macro: AD_AVG_EN
//   When defined, 2^AVG_LOG2 consecutive frames are summed per channel. The
//   floored mean (sum >>> AVG_LOG2) is output once per 2^AVG_LOG2 frames.
//   When undefined, every frame is output raw and AVG_LOG2 is ignored.
//
// Ports
//   ad_clk   in   system clock
//   rst_n    in   asynchronous, active-low reset
//   ad_start in   run enable (level); low aborts the current frame
//   ad_sdo   in   [NCH]        serial data, channel c on bit c
//   ad_cnv   out  conversion start (registered)
//   ad_sclk  out  serial clock, ad_clk/2 (registered)
//   ad_ncs   out  constant 1 (3-wire mode)
//   m_data   out  [NCH*DATA_W] channel c in [c*DATA_W +: DATA_W], two's complement
//   m_valid  out  frame available
//   m_ready  in   consumer accepts the frame
//   overrun  out  sticky: a completed frame was dropped (cleared while ad_start=0)
module ad79xx_multi_if #(
   parameter int CLK_MHZ    = 50,
   parameter int SAMPLE_CYC = 500,
   parameter int CONV_CYC   = 40,
   parameter int DATA_W     = 18,
   parameter int NCH        = 2,
   parameter int AVG_LOG2   = 2
) (
   input  logic                  ad_clk,
   input  logic                  rst_n,
   input  logic                  ad_start,
   input  logic [NCH-1:0]        ad_sdo,
   output logic                  ad_cnv,
   output logic                  ad_sclk,
   output logic                  ad_ncs,
   output logic [NCH*DATA_W-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  overrun
);

   localparam int CNT_W = $clog2(SAMPLE_CYC);
   localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYC - 1);
   localparam logic [CNT_W-1:0] READ_LAST   = CNT_W'(CONV_CYC + 2*DATA_W - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
   // SCLK is high on even offsets from the start of READ
   localparam logic CONV_PAR = 1'(CONV_CYC % 2);

   if (SAMPLE_CYC < CONV_CYC + 2*DATA_W + 4) begin : g_chk_period
      $error("ad79xx_multi_if: SAMPLE_CYC too small for CONV_CYC + 2*DATA_W + 4");
   end
   if (DATA_W < 12 || DATA_W > 20) begin : g_chk_dw
      $error("ad79xx_multi_if: DATA_W must be 12..20");
   end
   if (NCH < 1 || NCH > 8) begin : g_chk_nch
      $error("ad79xx_multi_if: NCH must be 1..8");
   end
   if (CLK_MHZ < 1 || AVG_LOG2 < 0 || AVG_LOG2 > 8) begin : g_chk_misc
      $error("ad79xx_multi_if: CLK_MHZ or AVG_LOG2 out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_READ, S_WAIT} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cnv_q, cnv_d;
   logic               sclk_q, sclk_d;
   logic [DATA_W-1:0]  sh_q [NCH];
   logic [NCH*DATA_W-1:0] data_q, data_d, frame_data;
   logic               valid_q, valid_d;
   logic               ovr_q, ovr_d;
   logic               frame_raw;
   logic               emit;

   // ---------------------------------------------------------------- sequencer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (ad_start) state_d = S_CONV;
         end
         S_CONV: if (cnt_q == CONV_LAST) state_d = S_READ;
         S_READ: if (cnt_q == READ_LAST) state_d = S_WAIT;
         S_WAIT: begin
            if (cnt_q == SAMPLE_LAST) begin
               state_d = S_CONV;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (!ad_start) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
      // outputs are registered from the next state so they align with it
      cnv_d  = (state_d == S_CONV);
      sclk_d = (state_d == S_READ) && (cnt_d[0] == CONV_PAR);
   end

   always_ff @(posedge ad_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cnv_q   <= 1'b0;
         sclk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cnv_q   <= cnv_d;
         sclk_q  <= sclk_d;
      end
   end

   // ------------------------------------------------------------ deserialiser
   // Sample at the end of each SCLK-high cycle, MSB first.
   always_ff @(posedge ad_clk) begin
      if (state_q == S_READ && sclk_q) begin
         for (int c = 0; c < NCH; c++) begin
            sh_q[c] <= {sh_q[c][DATA_W-2:0], ad_sdo[c]};
         end
      end
   end

   // last cycle of READ is the low half of the last SCLK period
   assign frame_raw = (state_q == S_READ) && (cnt_q == READ_LAST) && ad_start;

`ifdef AD_AVG_EN
   // --------------------------------------------------------------- averaging
   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int FC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'((1 << AVG_LOG2) - 1);

   logic signed [ACC_W-1:0] acc_q [NCH];
   logic signed [ACC_W-1:0] sum   [NCH];
   logic [FC_W-1:0]         fcnt_q;

   function automatic logic [DATA_W-1:0] avg_floor(input logic signed [ACC_W-1:0] s);
      logic signed [ACC_W-1:0] t;
      t = s >>> AVG_LOG2;
      return t[DATA_W-1:0];
   endfunction

   assign emit = frame_raw && (fcnt_q == FC_LAST);

   always_comb begin
      frame_data = '0;
      for (int c = 0; c < NCH; c++) begin
         sum[c] = acc_q[c] + ACC_W'(signed'(sh_q[c]));
         frame_data[c*DATA_W +: DATA_W] = avg_floor(sum[c]);
      end
   end

   always_ff @(posedge ad_clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q <= '0;
         for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
      end else if (!ad_start) begin
         fcnt_q <= '0;
         for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
      end else if (frame_raw) begin
         if (emit) begin
            fcnt_q <= '0;
            for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
         end else begin
            fcnt_q <= fcnt_q + FC_W'(1);
            for (int c = 0; c < NCH; c++) acc_q[c] <= sum[c];
         end
      end
   end
`else
   assign emit = frame_raw;

   always_comb begin
      frame_data = '0;
      for (int c = 0; c < NCH; c++) begin
         frame_data[c*DATA_W +: DATA_W] = sh_q[c];
      end
   end
`endif

   // ------------------------------------------------------------ output stage
   // A new frame may replace the held one only when the held one is leaving
   // this cycle; otherwise the new frame is dropped and overrun is flagged.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ovr_d   = ovr_q;
      if (valid_q && m_ready) valid_d = 1'b0;
      if (emit) begin
         if (!valid_q || m_ready) begin
            data_d  = frame_data;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
      if (!ad_start) ovr_d = 1'b0;
   end

   always_ff @(posedge ad_clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign ad_cnv  = cnv_q;
   assign ad_sclk = sclk_q;
   assign ad_ncs  = 1'b1;
   assign m_data  = data_q;
   assign m_valid = valid_q;
   assign overrun = ovr_q;

endmodule

// File: tb/tb_ad79xx_multi_if.sv
// Directed bench for ad79xx_multi_if with default parameters (DATA_W=18,
// NCH=2, CONV_CYC=40, SAMPLE_CYC=500). A behavioural two-channel ADC loads its
// sample on CNV rising and shifts the next bit out after every SCLK fall.
module tb_ad79xx_multi_if;

   localparam int DW  = 18;
   localparam int NC  = 2;
   localparam int CNV = 40;

   logic          ad_clk;
   logic          rst_n;
   logic          ad_start;
   logic [NC-1:0] ad_sdo;
   logic          ad_cnv;
   logic          ad_sclk;
   logic          ad_ncs;
   logic [NC*DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          overrun;

   ad79xx_multi_if dut (
      .ad_clk  (ad_clk),
      .rst_n   (rst_n),
      .ad_start(ad_start),
      .ad_sdo  (ad_sdo),
      .ad_cnv  (ad_cnv),
      .ad_sclk (ad_sclk),
      .ad_ncs  (ad_ncs),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .overrun (overrun)
   );

   initial ad_clk = 1'b0;
   always #5 ad_clk = ~ad_clk;

   // ADC model
   logic [DW-1:0] val0, val1, sh0, sh1;
   assign ad_sdo = {sh1[DW-1], sh0[DW-1]};

   always @(posedge ad_cnv or negedge ad_sclk) begin
      #1;
      if (ad_cnv) begin
         sh0 = val0;
         sh1 = val1;
      end else begin
         sh0 = {sh0[DW-2:0], 1'b0};
         sh1 = {sh1[DW-2:0], 1'b0};
      end
   end

   int nvec = 0;
   int nerr = 0;
   int first_valid, valid_cnt, sclk_rise, cnv_bad;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ad_clk);
      @(negedge ad_clk);
   endtask

   // Sample cycles 0..n-1 of the current run (called at the negedge of cycle 0),
   // returning at the negedge of cycle n.
   task automatic observe(input int n);
      logic prev;
      first_valid = -1;
      valid_cnt   = 0;
      sclk_rise   = 0;
      cnv_bad     = 0;
      prev        = ad_sclk;
      for (int t = 0; t < n; t++) begin
         if (ad_cnv !== (t < CNV)) cnv_bad++;
         if (ad_sclk === 1'b1 && prev === 1'b0) sclk_rise++;
         prev = ad_sclk;
         if (m_valid === 1'b1) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = t;
         end
         step();
      end
   endtask

   localparam logic [NC*DW-1:0] FR_A = {18'h3FFFF, 18'h2A5C3};
   localparam logic [NC*DW-1:0] FR_C = {18'h00F0F, 18'h12345};

   initial begin
      sh0      = '0;
      sh1      = '0;
      val0     = 18'h2A5C3;
      val1     = 18'h3FFFF;
      rst_n    = 1'b0;
      ad_start = 1'b0;
      m_ready  = 1'b1;
      step();
      step();
      chk("rst_cnv",     ad_cnv,  1'b0);
      chk("rst_sclk",    ad_sclk, 1'b0);
      chk("rst_ncs",     ad_ncs,  1'b1);
      chk("rst_valid",   m_valid, 1'b0);
      chk("rst_data",    m_data,  '0);
      chk("rst_overrun", overrun, 1'b0);

      // first period, consumer always ready
      rst_n = 1'b1;
      step();
      ad_start = 1'b1;
      step();
      chk("start_cnv_latency", ad_cnv, 1'b1);
      observe(500);
      chk("p1_cnv_window",  cnv_bad,     0);
      chk("p1_sclk_pulses", sclk_rise,   18);
      chk("p1_valid_cycle", first_valid, 76);
      chk("p1_valid_len",   valid_cnt,   1);
      chk("p1_data",        m_data,      FR_A);
      chk("p1_next_cnv",    ad_cnv,      1'b1);

      // consumer stalls for two periods: first frame held, second dropped
      m_ready = 1'b0;
      val0    = 18'h00001;
      val1    = 18'h20000;
      observe(500);
      chk("p2_valid_cycle", first_valid, 76);
      chk("p2_valid_len",   valid_cnt,   424);
      chk("p2_overrun",     overrun,     1'b0);
      observe(500);
      chk("p3_valid_held",  m_valid,     1'b1);
      chk("p3_data_held",   m_data,      FR_A);
      chk("p3_overrun",     overrun,     1'b1);
      m_ready = 1'b1;
      step();
      chk("accept_valid",   m_valid,     1'b0);
      chk("overrun_sticky", overrun,     1'b1);
      ad_start = 1'b0;
      step();
      chk("stop_overrun",   overrun,     1'b0);
      chk("stop_cnv",       ad_cnv,      1'b0);

      // abort in cycle 50 (mid-READ), then a clean restart
      val0     = 18'h12345;
      val1     = 18'h00F0F;
      ad_start = 1'b1;
      step();
      chk("restart_cnv", ad_cnv, 1'b1);
      observe(50);
      chk("c50_sclk_high", ad_sclk, 1'b1);
      ad_start = 1'b0;
      step();
      chk("abort_sclk", ad_sclk, 1'b0);
      chk("abort_cnv",  ad_cnv,  1'b0);
      observe(100);
      chk("abort_no_valid", valid_cnt, 0);
      chk("abort_no_sclk",  sclk_rise, 0);
      m_ready  = 1'b0;
      ad_start = 1'b1;
      step();
      observe(500);
      chk("p4_sclk_pulses", sclk_rise,   18);
      chk("p4_valid_cycle", first_valid, 76);
      chk("p4_valid_len",   valid_cnt,   424);
      chk("p4_data",        m_data,      FR_C);
      chk("p4_overrun",     overrun,     1'b0);

      // asynchronous reset in the middle of CONV
      step();
      step();
      step();
      step();
      step();
      chk("pre_rst_cnv",   ad_cnv,  1'b1);
      chk("pre_rst_valid", m_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cnv",   ad_cnv,  1'b0);
      chk("arst_valid", m_valid, 1'b0);
      chk("arst_data",  m_data,  '0);
      chk("arst_sclk",  ad_sclk, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
